// File: rtl/smmha_lane_dispatcher.sv
// rtl/smmha_lane_dispatcher.sv - round-robin lane dispatcher with in-order result merge
//
// Purpose: spreads one input word stream across N_LANES engine lanes in
// strict rotation (word k goes to lane k mod N_LANES). It then collects the
// engine results back in the same rotation, so the merged output keeps the
// input order.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   clear_i                  synchronous soft clear (dominates start_i)
//   start_i, len_i           job start pulse and job length in words
//   a_valid_i/a_ready_o/a_data_i           input stream
//   lane_valid_o/lane_ready_i/lane_data_o  per-lane operand streams
//   res_valid_i/res_ready_o/res_data_i     per-lane result streams
//   d_valid_o/d_ready_i/d_data_o           merged output stream
//   busy_o                   job in progress (RUN or DRAIN)
//   done_o                   one-cycle job-complete pulse
//   cnt_o                    words delivered on d in current/last job
module smmha_lane_dispatcher #(
  parameter int N_LANES = 4,
  parameter int DW      = 32,
  parameter int LEN_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DW-1:0]         a_data_i,
  output logic [N_LANES-1:0]    lane_valid_o,
  input  logic [N_LANES-1:0]    lane_ready_i,
  output logic [N_LANES*DW-1:0] lane_data_o,
  input  logic [N_LANES-1:0]    res_valid_i,
  output logic [N_LANES-1:0]    res_ready_o,
  input  logic [N_LANES*DW-1:0] res_data_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [DW-1:0]         d_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_W-1:0]      cnt_o
);

  localparam int PTR_W = $clog2(N_LANES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      accepted;
  logic [LEN_W-1:0]      cnt_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [N_LANES-1:0]    lane_vld;
  logic [N_LANES*DW-1:0] lane_dat;
  logic                  out_vld;
  logic [DW-1:0]         out_dat;
  logic                  done_q;

  logic                  a_hs;
  logic                  res_hs;
  logic                  d_hs;
  logic                  last_out;
  logic [N_LANES-1:0]    lane_hs;
  logic [N_LANES-1:0]    res_rdy;

  // The target lane may accept a new word when it is empty or is being
  // drained in this same cycle.
  assign a_ready_o = (state == RUN) && (issued < len_q) &&
                     (!lane_vld[wr_ptr] || lane_ready_i[wr_ptr]);
  assign a_hs      = a_valid_i && a_ready_o;
  assign lane_hs   = lane_vld & lane_ready_i;

  // Only the lane whose turn it is may hand over a result. Every other lane
  // keeps its result pending, which is what preserves input order. The
  // accepted < len_q guard stops stray results from entering after the job
  // has collected all of its words.
  always_comb begin
    res_rdy         = '0;
    res_rdy[rd_ptr] = (state != IDLE) && (accepted < len_q) &&
                      (!out_vld || d_ready_i);
  end

  assign res_ready_o = res_rdy;
  assign res_hs      = res_valid_i[rd_ptr] && res_rdy[rd_ptr];
  assign d_hs        = out_vld && d_ready_i;
  assign last_out    = d_hs && (cnt_q + 1'b1 == len_q);

  assign lane_valid_o = lane_vld;
  assign lane_data_o  = lane_dat;
  assign d_valid_o    = out_vld;
  assign d_data_o     = out_dat;
  assign busy_o       = (state != IDLE);
  assign done_o       = done_q;
  assign cnt_o        = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lane_vld <= '0;
      lane_dat <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lane_vld <= '0;
      lane_dat <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Per-lane one-entry registers: a load wins over a drain, so a
      // simultaneous drain and reload keeps the lane valid.
      for (int i = 0; i < N_LANES; i++) begin
        if (a_hs && (wr_ptr == PTR_W'(i))) begin
          lane_vld[i]          <= 1'b1;
          lane_dat[i*DW +: DW] <= a_data_i;
        end else if (lane_hs[i]) begin
          lane_vld[i] <= 1'b0;
        end
      end

      if (a_hs) begin
        wr_ptr <= wr_ptr + 1'b1;
        issued <= issued + 1'b1;
      end

      if (res_hs) begin
        out_vld  <= 1'b1;
        out_dat  <= res_data_i[rd_ptr*DW +: DW];
        rd_ptr   <= rd_ptr + 1'b1;
        accepted <= accepted + 1'b1;
      end else if (d_hs) begin
        out_vld <= 1'b0;
      end

      if (d_hs && (cnt_q < len_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              len_q    <= len_i;
              issued   <= '0;
              accepted <= '0;
              cnt_q    <= '0;
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              state    <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_out) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (a_hs && (issued + 1'b1 == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_out) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smmha_lane_dispatcher.sv
// tb/tb_smmha_lane_dispatcher.sv - self-checking bench for smmha_lane_dispatcher
module tb_smmha_lane_dispatcher;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear_i;
  logic            start_i;
  logic [LW-1:0]   len_i;
  logic            a_valid_i;
  logic            a_ready_o;
  logic [DW-1:0]   a_data_i;
  logic [N-1:0]    lane_valid_o;
  logic [N-1:0]    lane_ready_i;
  logic [N*DW-1:0] lane_data_o;
  logic [N-1:0]    res_valid_i;
  logic [N-1:0]    res_ready_o;
  logic [N*DW-1:0] res_data_i;
  logic            d_valid_o;
  logic            d_ready_i;
  logic [DW-1:0]   d_data_o;
  logic            busy_o;
  logic            done_o;
  logic [LW-1:0]   cnt_o;

  smmha_lane_dispatcher #(.N_LANES(N), .DW(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_data_o(lane_data_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Behavioural model: source words, engine lanes, observed traffic.
  logic [DW-1:0] src [64];
  int            src_n;
  int            src_idx;
  logic [DW-1:0] got [$];
  int            rx_lane [$];
  logic [DW-1:0] rx_data [$];
  logic          eng_full  [N];
  logic [DW-1:0] eng_dat   [N];
  int            eng_cnt   [N];
  int            eng_delay [N];
  int            a_prob, lr_prob, dr_prob;
  logic          d_hold;
  int            done_cnt, busy_seen, aready_seen, rr_multi, idle_rdy;
  int            cnt_at_done;
  logic          busy_at_done;

  function automatic int idx_of(input logic [DW-1:0] v);
    for (int k = 0; k < src_n; k++) if (src[k] == v) return k;
    return -1;
  endfunction

  task automatic flush_engines();
    for (int i = 0; i < N; i++) begin
      eng_full[i] = 1'b0;
      eng_cnt[i]  = 0;
      eng_dat[i]  = '0;
    end
  endtask

  task automatic drive_inputs();
    a_valid_i = 1'b0;
    a_data_i  = '0;
    if (src_idx < src_n && int'($urandom_range(99)) < a_prob) begin
      a_valid_i = 1'b1;
      a_data_i  = src[src_idx];
    end
    for (int i = 0; i < N; i++) begin
      lane_ready_i[i]        = !eng_full[i] && (int'($urandom_range(99)) < lr_prob);
      res_valid_i[i]         = eng_full[i] && (eng_cnt[i] == 0);
      res_data_i[i*DW +: DW] = eng_dat[i];
    end
    d_ready_i = !d_hold && (int'($urandom_range(99)) < dr_prob);
  endtask

  // One clock: sample handshakes at the negedge, then advance the model
  // just after the rising edge and drive fresh inputs.
  task automatic cycle();
    logic            ah, dh;
    logic [N-1:0]    lh, rh;
    logic [N*DW-1:0] ld;
    logic [DW-1:0]   dd;
    @(negedge clk);
    ah = a_valid_i && a_ready_o;
    lh = lane_valid_o & lane_ready_i;
    rh = res_valid_i & res_ready_o;
    dh = d_valid_o && d_ready_i;
    ld = lane_data_o;
    dd = d_data_o;
    if (busy_o) busy_seen++;
    if (a_ready_o) aready_seen++;
    if ($countones(res_ready_o) > 1) rr_multi++;
    if (!busy_o && (a_ready_o || res_ready_o != '0)) idle_rdy++;
    @(posedge clk);
    #1;
    if (ah) src_idx++;
    for (int i = 0; i < N; i++) begin
      if (eng_full[i] && eng_cnt[i] > 0) eng_cnt[i]--;
      if (rh[i]) eng_full[i] = 1'b0;
      if (lh[i]) begin
        rx_lane.push_back(i);
        rx_data.push_back(ld[i*DW +: DW]);
        eng_full[i] = 1'b1;
        eng_dat[i]  = ld[i*DW +: DW];
        eng_cnt[i]  = eng_delay[i];
      end
    end
    if (dh) got.push_back(dd);
    if (done_o) begin
      done_cnt++;
      cnt_at_done  = cnt_o;
      busy_at_done = busy_o;
    end
    drive_inputs();
  endtask

  task automatic begin_job(input int len, input logic [DW-1:0] base);
    src_n   = len;
    src_idx = 0;
    for (int k = 0; k < len; k++) src[k] = base + DW'(k);
    got.delete();
    rx_lane.delete();
    rx_data.delete();
    done_cnt = 0; busy_seen = 0; aready_seen = 0; rr_multi = 0; idle_rdy = 0;
    cnt_at_done = -1; busy_at_done = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) cycle();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (a_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got=%b exp=0", a_ready_o); end
    n_cmp++; if (lane_valid_o !== '0) begin n_err++; $display("FAIL reset_lane_valid got=%b exp=0", lane_valid_o); end
    n_cmp++; if (res_ready_o !== '0) begin n_err++; $display("FAIL reset_res_ready got=%b exp=0", res_ready_o); end
    n_cmp++; if (d_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_d_valid got=%b exp=0", d_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_cmp++; if (cnt_o !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    n_cmp++; if (lane_data_o !== '0) begin n_err++; $display("FAIL reset_lane_data got=%h exp=0", lane_data_o); end
    n_cmp++; if (d_data_o !== '0) begin n_err++; $display("FAIL reset_d_data got=%h exp=0", d_data_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic test_basic();
    bit ok;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    for (int i = 0; i < N; i++) eng_delay[i] = 0;
    begin_job(8, 32'd1);
    start_i = 1'b1; len_i = 16'd8;
    cycle();
    start_i = 1'b0;
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout got=%0d exp=1", done_cnt); end
    n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL basic_count got=%0d exp=8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      n_cmp++; if (got[k] !== DW'(k + 1)) begin n_err++; $display("FAIL basic_order[%0d] got=%0d exp=%0d", k, got[k], k + 1); end
    end
    for (int j = 0; j < rx_data.size(); j++) begin
      n_cmp++; if (rx_lane[j] != (int'(rx_data[j]) - 1) % N) begin n_err++; $display("FAIL basic_lane data=%0d got=%0d exp=%0d", rx_data[j], rx_lane[j], (int'(rx_data[j]) - 1) % N); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_once got=%0d exp=1", done_cnt); end
    n_cmp++; if (cnt_o !== 16'd8) begin n_err++; $display("FAIL basic_cnt got=%0d exp=8", cnt_o); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); end
  endtask

  task automatic test_reorder();
    bit ok;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    eng_delay[0] = 12; eng_delay[1] = 8; eng_delay[2] = 4; eng_delay[3] = 0;
    begin_job(4, 32'd1);
    start_i = 1'b1; len_i = 16'd4;
    cycle();
    start_i = 1'b0;
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL reorder_done_timeout got=%0d exp=1", done_cnt); end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL reorder_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_cmp++; if (got[k] !== DW'(k + 1)) begin n_err++; $display("FAIL reorder_order[%0d] got=%0d exp=%0d", k, got[k], k + 1); end
    end
    n_cmp++; if (rr_multi != 0) begin n_err++; $display("FAIL reorder_res_ready_onehot got=%0d exp=0", rr_multi); end
    for (int i = 0; i < N; i++) eng_delay[i] = 0;
  endtask

  task automatic test_zero_len();
    begin_job(0, 32'd0);
    start_i = 1'b1; len_i = 16'd0;
    cycle();
    start_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL zero_done_pulse got=%b exp=1", done_o); end
    cycle();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL zero_done_width got=%b exp=0", done_o); end
    repeat (4) cycle();
    n_cmp++; if (busy_seen != 0) begin n_err++; $display("FAIL zero_busy got=%0d exp=0", busy_seen); end
    n_cmp++; if (aready_seen != 0) begin n_err++; $display("FAIL zero_a_ready got=%0d exp=0", aready_seen); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL zero_done_once got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    begin_job(16, 32'hB000_0000);
    start_i = 1'b1; len_i = 16'd16;
    cycle();
    start_i = 1'b0;
    c = 0;
    while (got.size() < 3 && c < 100) begin cycle(); c++; end
    d_hold = 1'b1;
    repeat (20) cycle();
    n_cmp++; if (a_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_a_ready got=%b exp=0", a_ready_o); end
    n_cmp++; if (d_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_d_valid_held got=%b exp=1", d_valid_o); end
    d_hold = 1'b0;
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout got=%0d exp=1", done_cnt); end
    n_cmp++; if (got.size() != 16) begin n_err++; $display("FAIL bp_count got=%0d exp=16", got.size()); end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      n_cmp++; if (got[k] !== src[k]) begin n_err++; $display("FAIL bp_order[%0d] got=%h exp=%h", k, got[k], src[k]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_once got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap_ignore_start();
    bit ok;
    int lane5;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    begin_job(5, 32'd11);
    start_i = 1'b1; len_i = 16'd5;
    cycle();
    start_i = 1'b0;
    repeat (2) cycle();
    start_i = 1'b1; len_i = 16'd3;
    cycle();
    start_i = 1'b0;
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_done_timeout got=%0d exp=1", done_cnt); end
    lane5 = -1;
    for (int j = 0; j < rx_data.size(); j++) if (rx_data[j] == src[4]) lane5 = rx_lane[j];
    n_cmp++; if (lane5 != 0) begin n_err++; $display("FAIL wrap_word5_lane got=%0d exp=0", lane5); end
    n_cmp++; if (got.size() != 5) begin n_err++; $display("FAIL wrap_count got=%0d exp=5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      n_cmp++; if (got[k] !== src[k]) begin n_err++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", k, got[k], src[k]); end
    end
    n_cmp++; if (cnt_at_done != 5) begin n_err++; $display("FAIL wrap_cnt_at_done got=%0d exp=5", cnt_at_done); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL wrap_done_once got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_clear();
    bit ok;
    int c;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    begin_job(10, 32'h0000_0100);
    start_i = 1'b1; len_i = 16'd10;
    cycle();
    start_i = 1'b0;
    c = 0;
    while (src_idx < 3 && c < 50) begin cycle(); c++; end
    clear_i = 1'b1;
    start_i = 1'b1; len_i = 16'd7;
    cycle();
    clear_i = 1'b0;
    start_i = 1'b0;
    flush_engines();
    src_n = 0;
    got.delete();
    drive_inputs();
    repeat (6) cycle();
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL clear_no_done got=%0d exp=0", done_cnt); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL clear_busy got=%b exp=0", busy_o); end
    n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL clear_stale_out got=%0d exp=0", got.size()); end
    n_cmp++; if (cnt_o !== '0) begin n_err++; $display("FAIL clear_cnt got=%0d exp=0", cnt_o); end
    begin_job(2, 32'h0000_0900);
    start_i = 1'b1; len_i = 16'd2;
    cycle();
    start_i = 1'b0;
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL clear_new_timeout got=%0d exp=1", done_cnt); end
    n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL clear_new_count got=%0d exp=2", got.size()); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      n_cmp++; if (got[k] !== src[k]) begin n_err++; $display("FAIL clear_new_order[%0d] got=%h exp=%h", k, got[k], src[k]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL clear_new_done_once got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    int len, k;
    for (int job = 0; job < 6; job++) begin
      len     = int'($urandom_range(20, 1));
      a_prob  = int'($urandom_range(100, 30));
      lr_prob = int'($urandom_range(100, 30));
      dr_prob = int'($urandom_range(100, 30));
      for (int i = 0; i < N; i++) eng_delay[i] = int'($urandom_range(5));
      begin_job(len, {$urandom_range(65535, 1), 16'h0000});
      start_i = 1'b1; len_i = LW'(len);
      cycle();
      start_i = 1'b0;
      wait_done(2000, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd%0d_done_timeout got=%0d exp=1", job, done_cnt); end
      n_cmp++; if (got.size() != len) begin n_err++; $display("FAIL rnd%0d_count got=%0d exp=%0d", job, got.size(), len); end
      for (int m = 0; m < got.size() && m < len; m++) begin
        n_cmp++; if (got[m] !== src[m]) begin n_err++; $display("FAIL rnd%0d_order[%0d] got=%h exp=%h", job, m, got[m], src[m]); end
      end
      for (int j = 0; j < rx_data.size(); j++) begin
        k = idx_of(rx_data[j]);
        n_cmp++; if (k < 0 || rx_lane[j] != k % N) begin n_err++; $display("FAIL rnd%0d_lane data=%h got=%0d exp_index=%0d", job, rx_data[j], rx_lane[j], k); end
      end
      n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rnd%0d_done_once got=%0d exp=1", job, done_cnt); end
      n_cmp++; if (cnt_at_done != len) begin n_err++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", job, cnt_at_done, len); end
      n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy_at_done got=%b exp=0", job, busy_at_done); end
      n_cmp++; if (rr_multi != 0) begin n_err++; $display("FAIL rnd%0d_res_ready_onehot got=%0d exp=0", job, rr_multi); end
      n_cmp++; if (idle_rdy != 0) begin n_err++; $display("FAIL rnd%0d_idle_ready got=%0d exp=0", job, idle_rdy); end
    end
    for (int i = 0; i < N; i++) eng_delay[i] = 0;
  endtask

  task automatic test_reset_midjob();
    a_prob = 100; lr_prob = 100; dr_prob = 50; d_hold = 1'b0;
    begin_job(12, 32'h0000_0500);
    start_i = 1'b1; len_i = 16'd12;
    cycle();
    start_i = 1'b0;
    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy_o); end
    n_cmp++; if (a_ready_o !== 1'b0) begin n_err++; $display("FAIL arst_a_ready got=%b exp=0", a_ready_o); end
    n_cmp++; if (lane_valid_o !== '0) begin n_err++; $display("FAIL arst_lane_valid got=%b exp=0", lane_valid_o); end
    n_cmp++; if (d_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_d_valid got=%b exp=0", d_valid_o); end
    n_cmp++; if (res_ready_o !== '0) begin n_err++; $display("FAIL arst_res_ready got=%b exp=0", res_ready_o); end
    n_cmp++; if (cnt_o !== '0) begin n_err++; $display("FAIL arst_cnt got=%0d exp=0", cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    flush_engines();
    src_n = 0;
    @(posedge clk);
    #1;
    drive_inputs();
    done_cnt = 0;
    repeat (10) cycle();
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL arst_no_done got=%0d exp=0", done_cnt); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL arst_idle got=%b exp=0", busy_o); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    a_valid_i = 1'b0; a_data_i = '0; lane_ready_i = '0;
    res_valid_i = '0; res_data_i = '0; d_ready_i = 1'b0;
    a_prob = 100; lr_prob = 100; dr_prob = 100; d_hold = 1'b0;
    for (int i = 0; i < N; i++) eng_delay[i] = 0;
    flush_engines();
    begin_job(0, 32'd0);
    test_reset();
    test_basic();
    test_reorder();
    test_zero_len();
    test_backpressure();
    test_wrap_ignore_start();
    test_clear();
    test_random();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
